// File: rtl/alu_req_arbiter.sv
// -----------------------------------------------------------------------------
// alu_req_arbiter
//   Shares one combinational 16-bit ALU between two requesters using
//   round-robin arbitration. Only one operation is in flight at a time. The
//   winning operands and op code are registered and drive the ALU input bus.
//   The block waits the op latency, then captures the result into a response
//   that is held under a valid/ready handshake.
//
//   Ports
//     clk, reset            rising-edge clock; asynchronous active-low reset
//     reqN_valid/ready      N=0,1 request handshake (ready is high only in IDLE)
//     reqN_a, reqN_b        N=0,1 signed operands
//     reqN_ctrl             N=0,1 ALU op code
//     alu_in1/in2/ctrl      registered operands and op code sent to the ALU
//     alu_out/r0/ovf        ALU result, high half or remainder, overflow flag
//     rsp_valid/ready       response handshake
//     rsp_id/out/r0/ovf/err captured response fields
//     busy                  high whenever the FSM is not in IDLE
//
//   Build option
//     ALU_ARB_DIVZERO_CHK_EN : a divide with b==0 is not sent to the ALU. It
//                              returns out=all ones, r0=a, err=1.
// -----------------------------------------------------------------------------
module alu_req_arbiter #(
  parameter int WIDTH  = 16,
  parameter int MD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [WIDTH-1:0] alu_r0,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic [WIDTH-1:0] rsp_r0,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int CNT_W = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);

  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h8;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hE, 4'hF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic               rr_q, rr_d;          // 0: req0 wins a tie, 1: req1 wins
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               id_q, id_d;
  logic               bypass_q, bypass_d;  // op is answered locally, never issued
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   r0_q, r0_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;

  // Arbitration and selection of the winning request.
  logic             grant0, grant1;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [3:0]       sel_ctrl;
  logic             sel_bypass, sel_md;

  always_comb begin
    grant0 = req0_valid && (!req1_valid || !rr_q);
    grant1 = req1_valid && !grant0;

    // The reset term keeps ready low while reset is asserted, even though the
    // FSM already sits in IDLE during reset.
    req0_ready = reset && (state_q == S_IDLE) && grant0;
    req1_ready = reset && (state_q == S_IDLE) && grant1;

    sel_a    = grant1 ? req1_a    : req0_a;
    sel_b    = grant1 ? req1_b    : req0_b;
    sel_ctrl = grant1 ? req1_ctrl : req0_ctrl;

`ifdef ALU_ARB_DIVZERO_CHK_EN
    sel_bypass = !is_legal(sel_ctrl) || ((sel_ctrl == OP_DIV) && (sel_b == '0));
`else
    sel_bypass = !is_legal(sel_ctrl);
`endif
    sel_md = !sel_bypass && ((sel_ctrl == OP_MUL) || (sel_ctrl == OP_DIV));
  end

  // Next-state and datapath logic.
  logic capture;

  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d  = state_q;
    rr_d     = rr_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    id_d     = id_q;
    bypass_d = bypass_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    r0_d     = r0_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    capture  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0_ready || req1_ready) begin
          a_d      = sel_a;
          b_d      = sel_b;
          ctrl_d   = sel_ctrl;
          id_d     = grant1;
          bypass_d = sel_bypass;
          cnt_d    = sel_md ? CNT_W'(MD_LAT) : '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Capture happens in the same cycle the count reaches zero. The ALU
        // therefore sees the op for MD_LAT+1 cycles in total.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rr_d    = !id_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      if (bypass_q) begin
        out_d = '0;
        r0_d  = '0;
        ovf_d = 1'b0;
        err_d = 1'b1;
`ifdef ALU_ARB_DIVZERO_CHK_EN
        // Illegal codes are never OP_DIV, so a bypassed divide is a divide by zero.
        if (ctrl_q == OP_DIV) begin
          out_d = '1;
          r0_d  = a_q;
        end
`endif
      end else begin
        out_d = alu_out;
        r0_d  = alu_r0;
        ovf_d = alu_ovf;
        err_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= 4'h0;
      id_q     <= 1'b0;
      bypass_q <= 1'b0;
      cnt_q    <= '0;
      out_q    <= '0;
      r0_q     <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, independent of statement order.
      state_q  <= state_d;
      rr_q     <= rr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      id_q     <= id_d;
      bypass_q <= bypass_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      r0_q     <= r0_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // The ALU sees a real op code only while an issued op is in flight. At all
  // other times it receives 0 and holds its state; the operands simply keep
  // their last values.
  assign alu_in1   = a_q;
  assign alu_in2   = b_q;
  assign alu_ctrl  = (((state_q == S_ISSUE) || (state_q == S_WAIT)) && !bypass_q) ? ctrl_q : 4'h0;

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = id_q;
  assign rsp_out   = out_q;
  assign rsp_r0    = r0_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
